mult_gen_pipelined: RTL and testbench
=====================================

// Module: mult_gen_pipelined
// PURPOSE
//   Fixed-latency, fully pipelined unsigned integer multiplier: P = A * B.
//   Used as the multiply datapath of the integer multiply functional unit.
//   That unit holds its operands in registers and takes res = P[31:0] when its
//   own countdown reports finish. No handshake: one new operand pair is accepted
//   every cycle, and every product leaves after exactly LATENCY cycles.
// PARAMETERS
//   WIDTH    32  operand width in bits; product width is 2*WIDTH.
//   LATENCY  6   number of register stages from the operand-sampling edge to P.
//                Must be >= 1. The multiply FU's countdown assumes 6.
// PORTS
//   CLK  input   1        clock; all state updates on rising edge
//   RST  input   1        asynchronous, active-high reset
//   A    input   WIDTH    multiplicand, unsigned
//   B    input   WIDTH    multiplier, unsigned
//   P    output  2*WIDTH  full unsigned product, registered output
// BEHAVIOUR
//   - Clocking and reset: single clock domain. Reset is asynchronous and active-high.
//   - Reset:
//     - RST=1 immediately clears every pipeline register; P=0 while RST is held.
//     - After release, P stays 0 until the first post-reset operand pair arrives.
//     - Reset mid-operation discards all in-flight products. No partial results may appear.
//   - Timing: A,B are sampled at rising edge n. P = A*B becomes valid just after
//     edge n+LATENCY-1, counting edge n as stage 1, and holds for one cycle.
//     The next pair's product follows on the next cycle.
//   - Throughput: 1 product per cycle; no stalls, no enable, no valid flag.
//     The pipeline advances on every edge when RST=0.
//   - Back-to-back changes: operands changing on every cycle yield the
//     corresponding products on consecutive cycles, in issue order.
//   - Constant operands: if operands are held constant, P holds that product
//     from the LATENCY-th edge onward.
//   - Arithmetic: unsigned, exact 2*WIDTH-bit result; no overflow or truncation.
//     Signed interpretation is the caller's job. The low WIDTH bits equal the
//     two's-complement low product either way.
//   - Structure: split B into 8-bit digits and form WIDTH x 8 partial products in stage 1.
//     Reduce them in an adder tree spread across the remaining stages, with the final
//     sum registered into P. Delay-match any spare stages with registers so latency
//     is exactly LATENCY. No combinational path from A/B to P.
//   - Corner operands:
//     - 0*x = 0.
//     - 1*x = x.
//     - all-ones * all-ones = 2^(2W) - 2^(W+1) + 1.
// TESTING
//   1. Hold RST=1 with A=5, B=7 for 10 cycles -> P=0 throughout. Release RST ->
//      P=35 after the 6th edge and not before (5 edges show 0).
//   2. A=0xFFFFFFFF, B=0xFFFFFFFF -> P=0xFFFFFFFE00000001 exactly 6 edges later.
//   3. Stream (3,4), (0x10000,0x10000), (0x80000000,2), (0,0xDEADBEEF) on consecutive
//      cycles -> P = 12, 0x100000000, 0x100000000, 0 on consecutive cycles, in order.
//   4. A=0x12345678, B=1 -> P=0x0000000012345678. Also check the
//      A=1, B=0x12345678 swap gives the same result.
//   5. Pulse RST for part of one cycle while 3 products are in flight -> P drops
//      to 0 asynchronously. None of the 3 lost products ever appears.
//      New operands issued after release appear 6 edges later.
//   6. Random: 10k cycles of random A,B vs. a 64-bit reference model delayed by
//      LATENCY cycles -> zero mismatches.

Source files
------------

// File: rtl/mult_gen_pipelined_if.sv
// rtl/mult_gen_pipelined_if.sv - operand/product bundle for the pipelined multiplier
interface mult_gen_pipelined_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] p;

  modport master (output a, output b, input  p);
  modport slave  (input  a, input  b, output p);
endinterface

// File: rtl/mult_gen_pipelined.sv
// rtl/mult_gen_pipelined.sv - fixed-latency unsigned multiplier, 8-bit digit partial products + pipelined adder tree
module mult_gen_pipelined #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 6
) (
  input  logic                clk,
  input  logic                rst,
  mult_gen_pipelined_if.slave bus
);
  localparam int NDIG = (WIDTH + 7) / 8;
  localparam int PW   = 2 * WIDTH;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] stg [LATENCY][NDIG];
  logic [PW-1:0] nxt [LATENCY][NDIG];

  assign a_ext = {{(PW-WIDTH){1'b0}}, bus.a};
  assign b_ext = {{(PW-WIDTH){1'b0}}, bus.b};

  // Each middle stage halves the live term count; once one term is left it
  // simply rides along as a delay register. The last stage collapses whatever remains.
  always_comb begin
    for (int s = 0; s < LATENCY; s++) begin
      for (int k = 0; k < NDIG; k++) begin
        nxt[s][k] = '0;
      end
    end

    for (int k = 0; k < NDIG; k++) begin
      if (LATENCY == 1) begin
        nxt[0][0] = nxt[0][0] +
                    ((a_ext * {{(PW-8){1'b0}}, b_ext[8*k +: 8]}) << (8*k));
      end else begin
        nxt[0][k] = (a_ext * {{(PW-8){1'b0}}, b_ext[8*k +: 8]}) << (8*k);
      end
    end

    for (int s = 1; s < LATENCY; s++) begin
      for (int k = 0; k < NDIG; k++) begin
        if (s == LATENCY - 1) begin
          nxt[s][0] = nxt[s][0] + stg[s-1][k];
        end else begin
          nxt[s][k >> 1] = nxt[s][k >> 1] + stg[s-1][k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        for (int k = 0; k < NDIG; k++) begin
          stg[s][k] <= '0;
        end
      end
    end else begin
      stg <= nxt;
    end
  end

  assign bus.p = stg[LATENCY-1][0];
endmodule

// File: tb/tb_mult_gen_pipelined.sv
// tb/tb_mult_gen_pipelined.sv - directed and random checks of the pipelined multiplier
module tb_mult_gen_pipelined;
  localparam int LAT = 6;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mult_gen_pipelined_if #(.WIDTH(32)) bus ();

  mult_gen_pipelined #(.WIDTH(32), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  vec_t        vecs [10];
  logic [31:0] sa [4];
  logic [63:0] sp [4];
  logic [63:0] hist [$];
  logic [31:0] ra, rb;
  logic [63:0] exp_p;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678};
    vecs[2] = '{32'h0000_0001, 32'h1234_5678, 64'h0000_0000_1234_5678};
    vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
    vecs[4] = '{32'hCAFE_F00D, 32'h0000_0000, 64'h0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000};
    vecs[7] = '{32'h0000_00FF, 32'h0000_0101, 64'h0000_0000_0000_FFFF};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
    vecs[9] = '{32'h0100_0000, 32'h0100_0000, 64'h0001_0000_0000_0000};

    // Reset held with live operands: output must stay cleared.
    bus.a = 32'd5;
    bus.b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_hold%0d", i), bus.p, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      check($sformatf("first_edge%0d", e), bus.p, (e == LAT) ? 64'd35 : 64'd0);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.a = vecs[i].a;
      bus.b = vecs[i].b;
      repeat (LAT) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), bus.p, vecs[i].p);
    end

    // Back-to-back stream, followed by a held pair.
    sa[0] = 32'd3;         sp[0] = 64'd12;
    sa[1] = 32'h0001_0000; sp[1] = 64'h1_0000_0000;
    sa[2] = 32'h8000_0000; sp[2] = 64'h1_0000_0000;
    sa[3] = 32'd0;         sp[3] = 64'd0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      case (e)
        1: begin bus.a = sa[0]; bus.b = 32'd4;          end
        2: begin bus.a = sa[1]; bus.b = 32'h0001_0000;  end
        3: begin bus.a = sa[2]; bus.b = 32'd2;          end
        4: begin bus.a = sa[3]; bus.b = 32'hDEAD_BEEF;  end
        default: begin bus.a = 32'd7; bus.b = 32'd9;    end
      endcase
      @(posedge clk); #1;
      if (e >= 6 && e <= 9)
        check($sformatf("stream%0d", e - 6), bus.p, sp[e-6]);
      else if (e == 10)
        check("stream_tail", bus.p, 64'd63);
    end

    // Partial-cycle reset pulse with three products in flight.
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      bus.a = (e == 1) ? 32'd2 : (e == 2) ? 32'd5 : 32'd9;
      bus.b = (e == 1) ? 32'd3 : (e == 2) ? 32'd5 : 32'd9;
      @(posedge clk);
    end
    #2 rst = 1'b1;
    #1 check("async_clear", bus.p, 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    bus.a = 32'd11;
    bus.b = 32'd13;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      check($sformatf("post_pulse%0d", e), bus.p, (e == LAT) ? 64'd143 : 64'd0);
    end

    // Random stream against a delayed reference.
    hist.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      if (c % 97 == 0) ra = 32'hFFFF_FFFF;
      if (c % 89 == 0) rb = 32'd0;
      bus.a = ra;
      bus.b = rb;
      hist.push_back({32'd0, ra} * {32'd0, rb});
      @(posedge clk); #1;
      if (hist.size() == LAT) begin
        exp_p = hist.pop_front();
        check("random", bus.p, exp_p);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
